// File: rtl/sprite_palette_ram.sv
// Shared sprite colour lookup table. The NIOS loads the palettes over Avalon-MM,
// and the VGA path reads them through a 2-stage pipeline that applies a global
// brightness (fade) and flags the transparent colour index.
module sprite_palette_ram #(
  parameter int unsigned BANKS   = 4,
  parameter int unsigned INDEX_W = 8,
  parameter int unsigned CH_W    = 4,
  localparam int unsigned BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1,
  localparam int unsigned AW     = BANK_W + INDEX_W + 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [AW-1:0]      avl_address,
  input  logic               avl_read,
  input  logic               avl_write,
  input  logic [31:0]        avl_writedata,
  output logic [31:0]        avl_readdata,
  output logic               avl_readdatavalid,
  output logic               avl_waitrequest,
  input  logic               pix_valid,
  input  logic [BANK_W-1:0]  pix_bank,
  input  logic [INDEX_W-1:0] pix_index,
  output logic               pix_valid_out,
  output logic [CH_W-1:0]    red,
  output logic [CH_W-1:0]    green,
  output logic [CH_W-1:0]    blue,
  output logic               pix_transparent
);

  localparam int unsigned EW     = 3 * CH_W;
  localparam int unsigned RAM_AW = BANK_W + INDEX_W;
  localparam int unsigned DEPTH  = BANKS * (2 ** INDEX_W);
  localparam int unsigned PW     = CH_W + 5;

  // With a single bank the bank bit is forced to 0 so addresses stay inside the RAM.
  localparam logic [BANK_W-1:0] BANK_MASK  = BANK_W'(BANKS - 1);
  localparam logic [RAM_AW-1:0] LAST_ENTRY = RAM_AW'(DEPTH - 1);
  localparam logic [4:0]        BRIGHT_MAX = 5'd16;

  localparam logic [AW-2:0] OFF_BRIGHT = (AW-1)'(0);
  localparam logic [AW-2:0] OFF_STATUS = (AW-1)'(1);
  localparam logic [AW-2:0] OFF_KEY    = (AW-1)'(2);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e              state_q;
  logic [RAM_AW-1:0]   clear_cnt_q;
  logic                busy_q;

  logic [4:0]          brightness_q;
  logic [INDEX_W-1:0]  trans_key_q;

  logic [31:0]         readdata_q;
  logic                readdatavalid_q;

  logic                s1_valid_q;
  logic [EW-1:0]       s1_data_q;
  logic                s1_match_q;

  logic                valid_out_q;
  logic [CH_W-1:0]     red_q, green_q, blue_q;
  logic                trans_q;

  logic [EW-1:0]       ram [DEPTH];

  logic                acc_wr, acc_rd, is_ctrl;
  logic [AW-2:0]       ctrl_off;
  logic [RAM_AW-1:0]   avl_entry, pix_entry;
  logic                b_we;
  logic [RAM_AW-1:0]   b_addr;
  logic [EW-1:0]       b_wdata;
  logic [31:0]         rd_value;

  // Channel scale: (c * brightness) >> 4 at CH_W+5 bits, truncated to CH_W.
  function automatic logic [CH_W-1:0] scale(input logic [CH_W-1:0] c, input logic [4:0] b);
    logic [PW-1:0] p;
    p = PW'(c) * PW'(b);
    return p[CH_W+3:4];
  endfunction

  // Accesses are only accepted once the clear has finished; read+write acts as write.
  assign acc_wr    = avl_write & ~busy_q;
  assign acc_rd    = avl_read & ~avl_write & ~busy_q;
  assign is_ctrl   = avl_address[AW-1];
  assign ctrl_off  = avl_address[AW-2:0];
  assign avl_entry = {avl_address[AW-2:INDEX_W] & BANK_MASK, avl_address[INDEX_W-1:0]};
  assign pix_entry = {pix_bank & BANK_MASK, pix_index};

  // FSM: sweep every entry to zero once after reset, then run forever.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StInit;
      clear_cnt_q <= '0;
      busy_q      <= 1'b1;
    end else begin
      unique case (state_q)
        StInit: begin
          clear_cnt_q <= clear_cnt_q + RAM_AW'(1);
          if (clear_cnt_q == LAST_ENTRY) begin
            state_q <= StRun;
            busy_q  <= 1'b0;
          end
        end
        StRun: begin
        end
      endcase
    end
  end

  // Port B owner: the clear sweep while busy, Avalon palette writes afterwards.
  always_comb begin
    b_we    = 1'b0;
    b_addr  = avl_entry;
    b_wdata = avl_writedata[EW-1:0];
    if (busy_q) begin
      b_we    = 1'b1;
      b_addr  = clear_cnt_q;
      b_wdata = '0;
    end else if (acc_wr && !is_ctrl) begin
      b_we = 1'b1;
    end
  end

  // Palette storage; same-edge readers see the pre-write contents.
  always_ff @(posedge clk) begin
    if (b_we) begin
      ram[b_addr] <= b_wdata;
    end
  end

  // Control registers: brightness saturates at unity gain, status is read-only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      brightness_q <= BRIGHT_MAX;
      trans_key_q  <= '0;
    end else if (acc_wr && is_ctrl) begin
      if (ctrl_off == OFF_BRIGHT) begin
        brightness_q <= (avl_writedata > 32'd16) ? BRIGHT_MAX : avl_writedata[4:0];
      end
      if (ctrl_off == OFF_KEY) begin
        trans_key_q <= avl_writedata[INDEX_W-1:0];
      end
    end
  end

  // Avalon read mux: palette entry zero-extended, or a control register.
  always_comb begin
    rd_value = '0;
    if (!is_ctrl) begin
      rd_value[EW-1:0] = ram[avl_entry];
    end else begin
      case (ctrl_off)
        OFF_BRIGHT: rd_value[4:0]         = brightness_q;
        OFF_STATUS: rd_value[0]           = busy_q;
        OFF_KEY:    rd_value[INDEX_W-1:0] = trans_key_q;
        default:    rd_value              = '0;
      endcase
    end
  end

  // Read response: fixed 1-cycle latency, data held until the next accepted read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_q      <= '0;
      readdatavalid_q <= 1'b0;
    end else begin
      readdatavalid_q <= acc_rd;
      if (acc_rd) begin
        readdata_q <= rd_value;
      end
    end
  end

  // Pixel stage 1: port A lookup, transparent-key compare, valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_match_q <= 1'b0;
    end else begin
      s1_valid_q <= pix_valid;
      if (pix_valid) begin
        s1_data_q  <= ram[pix_entry];
        s1_match_q <= (pix_index == trans_key_q);
      end
    end
  end

  // Pixel stage 2: brightness scale; busy blanks the pixel; outputs hold when idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_out_q <= 1'b0;
      red_q       <= '0;
      green_q     <= '0;
      blue_q      <= '0;
      trans_q     <= 1'b0;
    end else begin
      valid_out_q <= s1_valid_q;
      if (s1_valid_q) begin
        if (busy_q) begin
          red_q   <= '0;
          green_q <= '0;
          blue_q  <= '0;
          trans_q <= 1'b1;
        end else begin
          red_q   <= scale(s1_data_q[EW-1 -: CH_W], brightness_q);
          green_q <= scale(s1_data_q[2*CH_W-1 -: CH_W], brightness_q);
          blue_q  <= scale(s1_data_q[CH_W-1:0], brightness_q);
          trans_q <= s1_match_q;
        end
      end
    end
  end

  assign avl_waitrequest   = busy_q;
  assign avl_readdata      = readdata_q;
  assign avl_readdatavalid = readdatavalid_q;
  assign pix_valid_out     = valid_out_q;
  assign red               = red_q;
  assign green             = green_q;
  assign blue              = blue_q;
  assign pix_transparent   = trans_q;

endmodule

// File: tb/tb_sprite_palette_ram.sv
// Randomised bench for sprite_palette_ram with a scoreboard: the stimulus side
// pushes expected responses, negedge monitors pop and compare.
module tb_sprite_palette_ram;

  localparam int unsigned BANKS   = 4;
  localparam int unsigned INDEX_W = 8;
  localparam int unsigned CH_W    = 4;
  localparam int unsigned BANK_W  = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam int unsigned AW      = BANK_W + INDEX_W + 1;
  localparam int unsigned DEPTH   = BANKS * (2 ** INDEX_W);
  localparam int unsigned EW      = 3 * CH_W;

  logic               clk = 1'b0;
  logic               reset_n = 1'b1;
  logic [AW-1:0]      avl_address = '0;
  logic               avl_read = 1'b0;
  logic               avl_write = 1'b0;
  logic [31:0]        avl_writedata = '0;
  logic [31:0]        avl_readdata;
  logic               avl_readdatavalid;
  logic               avl_waitrequest;
  logic               pix_valid = 1'b0;
  logic [BANK_W-1:0]  pix_bank = '0;
  logic [INDEX_W-1:0] pix_index = '0;
  logic               pix_valid_out;
  logic [CH_W-1:0]    red, green, blue;
  logic               pix_transparent;

  sprite_palette_ram #(.BANKS(BANKS), .INDEX_W(INDEX_W), .CH_W(CH_W)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .avl_address       (avl_address),
    .avl_read          (avl_read),
    .avl_write         (avl_write),
    .avl_writedata     (avl_writedata),
    .avl_readdata      (avl_readdata),
    .avl_readdatavalid (avl_readdatavalid),
    .avl_waitrequest   (avl_waitrequest),
    .pix_valid         (pix_valid),
    .pix_bank          (pix_bank),
    .pix_index         (pix_index),
    .pix_valid_out     (pix_valid_out),
    .red               (red),
    .green             (green),
    .blue              (blue),
    .pix_transparent   (pix_transparent)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [EW-1:0] rgb;
    logic          trans;
    int unsigned   cyc;
  } pix_exp_t;

  typedef struct {
    logic [31:0] data;
    int unsigned cyc;
  } avl_exp_t;

  pix_exp_t pix_q[$];
  avl_exp_t avl_q[$];
  pix_exp_t mon_p;
  avl_exp_t mon_a;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned cyc = 0;

  // Reference model state
  logic [EW-1:0]      m_mem [DEPTH];
  int unsigned        m_bright;
  logic [INDEX_W-1:0] m_key;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [EW-1:0] model_scale(input logic [EW-1:0] c, input int unsigned b);
    int unsigned r, g, bl;
    r  = (int'(c[EW-1 -: CH_W]) * b) / 16;
    g  = (int'(c[2*CH_W-1 -: CH_W]) * b) / 16;
    bl = (int'(c[CH_W-1:0]) * b) / 16;
    return {r[CH_W-1:0], g[CH_W-1:0], bl[CH_W-1:0]};
  endfunction

  function automatic logic [AW-1:0] pal_addr(input int unsigned bank, input int unsigned idx);
    logic [BANK_W-1:0]  b = BANK_W'(bank);
    logic [INDEX_W-1:0] i = INDEX_W'(idx);
    return {1'b0, b, i};
  endfunction

  function automatic logic [AW-1:0] ctrl_addr(input int unsigned off);
    return {1'b1, (AW-1)'(off)};
  endfunction

  function automatic int unsigned addr_entry(input logic [AW-1:0] a);
    return int'(a[AW-2:INDEX_W]) * (2 ** INDEX_W) + int'(a[INDEX_W-1:0]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = '0;
    m_bright = 16;
    m_key    = '0;
  endtask

  // One RUN-mode cycle of stimulus plus the model's view of it.
  task automatic drive(input bit do_pix, input int unsigned pb, input int unsigned pi,
                       input bit do_rd, input bit do_wr, input logic [AW-1:0] addr,
                       input logic [31:0] wd);
    pix_exp_t    ep;
    avl_exp_t    ea;
    bit          wr, rd, ctrl;
    int unsigned off;
    pix_valid     = do_pix;
    pix_bank      = BANK_W'(pb);
    pix_index     = INDEX_W'(pi);
    avl_read      = do_rd;
    avl_write     = do_wr;
    avl_address   = addr;
    avl_writedata = wd;
    wr   = do_wr;
    rd   = do_rd && !do_wr;
    ctrl = addr[AW-1];
    off  = int'(addr[AW-2:0]);
    // A brightness write applies to pixels issued in the same cycle or later.
    if (wr && ctrl && off == 0) m_bright = (wd > 32'd16) ? 16 : int'(wd);
    if (do_pix) begin
      ep.rgb   = model_scale(m_mem[pb * (2 ** INDEX_W) + pi], m_bright);
      ep.trans = (int'(m_key) == int'(pi));
      ep.cyc   = cyc + 2;
      pix_q.push_back(ep);
    end
    if (rd) begin
      ea.data = '0;  // status (not busy) and unmapped offsets read 0
      if (!ctrl) ea.data = 32'(m_mem[addr_entry(addr)]);
      else if (off == 0) ea.data = m_bright;
      else if (off == 2) ea.data = 32'(m_key);
      ea.cyc = cyc + 1;
      avl_q.push_back(ea);
    end
    if (wr && !ctrl) m_mem[addr_entry(addr)] = wd[EW-1:0];
    if (wr && ctrl && off == 2) m_key = wd[INDEX_W-1:0];
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    avl_read  = 1'b0;
    avl_write = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    for (int i = 0; i < int'(n); i++) drive(0, 0, 0, 0, 0, '0, '0);
  endtask

  // Count busy cycles after reset release; optionally probe the pixel path meanwhile.
  task automatic wait_init(input string name, input bit probe);
    int unsigned n = 0;
    pix_exp_t    ep;
    while (avl_waitrequest && n < 3000) begin
      if (probe && n < 4) begin
        pix_valid = 1'b1;
        pix_bank  = BANK_W'($urandom_range(0, BANKS - 1));
        pix_index = INDEX_W'($urandom_range(0, 255));
        ep.rgb    = '0;
        ep.trans  = 1'b1;
        ep.cyc    = cyc + 2;
        pix_q.push_back(ep);
      end else begin
        pix_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      n++;
    end
    pix_valid = 1'b0;
    check(name, n, DEPTH);
  endtask

  // Scoreboard monitors
  always @(negedge clk) begin
    if (reset_n) begin
      if (avl_readdatavalid) begin
        if (avl_q.size() == 0) begin
          check("avl_spurious_valid", 32'(avl_readdatavalid), 32'd0);
        end else begin
          mon_a = avl_q.pop_front();
          check("avl_latency", cyc, mon_a.cyc);
          check("avl_readdata", avl_readdata, mon_a.data);
        end
      end
      if (pix_valid_out) begin
        if (pix_q.size() == 0) begin
          check("pix_spurious_valid", 32'(pix_valid_out), 32'd0);
        end else begin
          mon_p = pix_q.pop_front();
          check("pix_latency", cyc, mon_p.cyc);
          check("pix_rgb", 32'({red, green, blue}), 32'(mon_p.rgb));
          check("pix_transparent", 32'(pix_transparent), 32'(mon_p.trans));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          do_pix, do_rd, do_wr;
    int unsigned pb, pi, op, off;
    logic [31:0] wd;
    logic [AW-1:0] addr;

    model_reset();
    #3 reset_n = 1'b0;
    #1;
    check("reset_waitrequest", 32'(avl_waitrequest), 32'd1);
    check("reset_readdata", avl_readdata, 32'd0);
    check("reset_readdatavalid", 32'(avl_readdatavalid), 32'd0);
    check("reset_pix_valid_out", 32'(pix_valid_out), 32'd0);
    check("reset_rgb", 32'({red, green, blue}), 32'd0);
    check("reset_transparent", 32'(pix_transparent), 32'd0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    wait_init("init_length", 1'b1);
    idle(3);
    drive(0, 0, 0, 1, 0, ctrl_addr(1), '0);  // status: not busy
    drive(0, 0, 0, 1, 0, ctrl_addr(0), '0);  // brightness reset value
    drive(0, 0, 0, 1, 0, ctrl_addr(2), '0);  // trans_key reset value
    drive(0, 0, 0, 1, 0, pal_addr(3, 'hFF), '0);  // cleared entry

    // Basic write / lookup / readback
    drive(0, 0, 0, 0, 1, pal_addr(2, 'h37), 32'h0000_0ABC);
    drive(1, 2, 'h37, 1, 0, pal_addr(2, 'h37), '0);
    idle(3);

    // Brightness scaling and clamp
    drive(0, 0, 0, 0, 1, ctrl_addr(0), 32'd8);
    drive(0, 0, 0, 0, 1, pal_addr(1, 'h05), 32'h0000_0F84);
    drive(1, 1, 'h05, 0, 0, '0, '0);
    drive(0, 0, 0, 0, 1, ctrl_addr(0), 32'd31);
    drive(1, 1, 'h05, 1, 0, ctrl_addr(0), '0);
    idle(3);

    // Transparent key on back-to-back pixels
    drive(0, 0, 0, 0, 1, ctrl_addr(2), 32'h10);
    drive(0, 0, 0, 0, 1, pal_addr(3, 'h0F), 32'h111);
    drive(0, 0, 0, 0, 1, pal_addr(3, 'h10), 32'h222);
    drive(0, 0, 0, 0, 1, pal_addr(3, 'h11), 32'h333);
    drive(1, 3, 'h0F, 0, 0, '0, '0);
    drive(1, 3, 'h10, 0, 0, '0, '0);
    drive(1, 3, 'h11, 0, 0, '0, '0);
    idle(3);

    // Same-cycle write and pixel read of one entry: pixel sees old data
    drive(0, 0, 0, 0, 1, pal_addr(0, 'h20), 32'h123);
    drive(1, 0, 'h20, 0, 1, pal_addr(0, 'h20), 32'h456);
    drive(1, 0, 'h20, 1, 0, pal_addr(0, 'h20), '0);
    idle(3);

    // Brightness timing relative to pixels in flight
    drive(1, 0, 'h20, 0, 1, ctrl_addr(0), 32'd8);
    drive(1, 0, 'h20, 0, 1, ctrl_addr(0), 32'd16);
    drive(1, 0, 'h20, 0, 0, '0, '0);
    idle(3);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      do_pix = ($urandom_range(0, 99) < 60);
      pb     = $urandom_range(0, BANKS - 1);
      pi     = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 15);
      op     = $urandom_range(0, 9);
      wd     = $urandom;
      do_rd  = 1'b0;
      do_wr  = 1'b0;
      addr   = pal_addr($urandom_range(0, BANKS - 1), $urandom_range(0, 15));
      off    = $urandom_range(0, 6);
      case (op)
        0, 1, 2: do_wr = 1'b1;
        3, 4:    do_rd = 1'b1;
        5: begin
          do_rd = 1'b1;
          addr  = ctrl_addr(off);
        end
        6: begin
          do_wr = 1'b1;
          addr  = ctrl_addr(off);
          if (off == 0 && $urandom_range(0, 3) != 0) wd = $urandom_range(0, 20);
          if (off == 2) wd = $urandom_range(0, 15);
        end
        7: begin
          do_rd = 1'b1;
          do_wr = 1'b1;
        end
        default: ;
      endcase
      drive(do_pix, pb, pi, do_rd, do_wr, addr, wd);
    end
    idle(4);
    check("avl_queue_drained", avl_q.size(), 0);
    check("pix_queue_drained", pix_q.size(), 0);

    // Leave non-zero outputs behind, then reset asynchronously mid-RUN
    drive(0, 0, 0, 0, 1, ctrl_addr(0), 32'd16);
    drive(0, 0, 0, 0, 1, ctrl_addr(2), 32'h05);
    drive(0, 0, 0, 0, 1, pal_addr(0, 'h05), 32'h9A7);
    drive(1, 0, 'h05, 1, 0, pal_addr(0, 'h05), '0);
    idle(3);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_waitrequest", 32'(avl_waitrequest), 32'd1);
    check("async_reset_readdata", avl_readdata, 32'd0);
    check("async_reset_rgb", 32'({red, green, blue}), 32'd0);
    check("async_reset_transparent", 32'(pix_transparent), 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    model_reset();
    wait_init("reinit_length", 1'b0);
    drive(0, 0, 0, 1, 0, pal_addr(2, 'h37), '0);
    drive(0, 0, 0, 1, 0, pal_addr(0, 'h05), '0);
    drive(0, 0, 0, 1, 0, ctrl_addr(0), '0);
    drive(0, 0, 0, 1, 0, ctrl_addr(2), '0);
    drive(1, 2, 'h37, 0, 0, '0, '0);
    idle(4);
    check("final_avl_queue_drained", avl_q.size(), 0);
    check("final_pix_queue_drained", pix_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
